// File: rtl/fpu_ss_regfile_sb.sv
// -----------------------------------------------------------------------------
// fpu_ss_regfile_sb
//   Floating-point register file for the FPU subsystem with a per-register
//   scoreboard (busy bit = write pending). Issue logic reads operands and busy
//   status and reserves rd at issue; FPU/LSU writeback ports write results and
//   clear the busy bit of the written register.
//
// Ports
//   clk_i            clock, all state updates on the rising edge
//   rst_i            synchronous reset, active-high (clears data, busy, collide)
//   raddr_i/rdata_o  NUM_RPORTS combinational read ports
//   rbusy_o          busy bit of each read address (registered state only)
//   waddr_i/wdata_i  NUM_WPORTS write ports; higher index wins on same address
//   we_i             per-port write enable
//   reserve_*        one reservation request per cycle, valid/ready handshake
//   flush_i          clears every busy bit and kills a same-cycle reservation
//   busy_o           full scoreboard vector
//   wcollide_o       one-cycle pulse after >=2 enabled ports hit one register
// -----------------------------------------------------------------------------
module fpu_ss_regfile_sb #(
  parameter int unsigned FLEN       = 32,
  parameter int unsigned NUM_WORDS  = 32,
  parameter int unsigned NUM_RPORTS = 3,
  parameter int unsigned NUM_WPORTS = 2,
  parameter int unsigned FORWARD    = 1,
  localparam int unsigned AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_RPORTS-1:0][AW-1:0]         raddr_i,
  output logic [NUM_RPORTS-1:0][FLEN-1:0]       rdata_o,
  output logic [NUM_RPORTS-1:0]                 rbusy_o,
  input  logic [NUM_WPORTS-1:0][AW-1:0]         waddr_i,
  input  logic [NUM_WPORTS-1:0][FLEN-1:0]       wdata_i,
  input  logic [NUM_WPORTS-1:0]                 we_i,
  input  logic                                  reserve_valid_i,
  input  logic [AW-1:0]                         reserve_addr_i,
  output logic                                  reserve_ready_o,
  input  logic                                  flush_i,
  output logic [NUM_WORDS-1:0]                  busy_o,
  output logic                                  wcollide_o
);

  logic [FLEN-1:0]                 mem_q [NUM_WORDS];
  logic [NUM_WORDS-1:0]            busy_q;
  logic                            wcollide_q;

  // Per-register write decode: winning enable and data after port priority.
  logic [NUM_WORDS-1:0]            wr_en;
  logic [NUM_WORDS-1:0][FLEN-1:0]  wr_data;
  logic                            collide;
  logic                            res_busy;

  // Ports are scanned in ascending order so the highest-index enabled port
  // overwrites lower ones. Addresses beyond NUM_WORDS never match a register,
  // so such writes fall away naturally.
  // NOTE: every combinational output gets a default before the loops; without
  // it a register with no matching port would infer a latch.
  always_comb begin
    wr_en   = '0;
    wr_data = '0;
    for (int r = 0; r < int'(NUM_WORDS); r++) begin
      for (int p = 0; p < int'(NUM_WPORTS); p++) begin
        if (we_i[p] && (waddr_i[p] == AW'(r))) begin
          wr_en[r]   = 1'b1;
          wr_data[r] = wdata_i[p];
        end
      end
    end
  end

  // Collision: any pair of enabled ports targeting the same existing register.
  always_comb begin
    collide = 1'b0;
    for (int p = 0; p < int'(NUM_WPORTS); p++) begin
      for (int q = p + 1; q < int'(NUM_WPORTS); q++) begin
        if (we_i[p] && we_i[q] && (waddr_i[p] == waddr_i[q]) &&
            (32'(waddr_i[p]) < NUM_WORDS)) begin
          collide = 1'b1;
        end
      end
    end
  end

  // Read ports. Data may be forwarded from a same-cycle write; busy never is,
  // so issue logic only sees a register free once the clear has landed.
  always_comb begin
    rdata_o = '0;
    rbusy_o = '0;
    for (int i = 0; i < int'(NUM_RPORTS); i++) begin
      for (int r = 0; r < int'(NUM_WORDS); r++) begin
        if (raddr_i[i] == AW'(r)) begin
          rdata_o[i] = ((FORWARD != 0) && wr_en[r]) ? wr_data[r] : mem_q[r];
          rbusy_o[i] = busy_q[r];
        end
      end
    end
  end

  // Reservation lookup against registered busy state (no bypass of a clear).
  always_comb begin
    res_busy = 1'b0;
    for (int r = 0; r < int'(NUM_WORDS); r++) begin
      if (reserve_addr_i == AW'(r)) res_busy = busy_q[r];
    end
  end

  assign reserve_ready_o = reserve_valid_i && !res_busy && !flush_i;

  // NOTE: all state below is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  // NOTE: the data array is reset as well; reads after reset must return 0,
  // which rules out an unreset array.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < int'(NUM_WORDS); r++) mem_q[r] <= '0;
      wcollide_q <= 1'b0;
    end else begin
      for (int r = 0; r < int'(NUM_WORDS); r++) begin
        if (wr_en[r]) mem_q[r] <= wr_data[r];
      end
      wcollide_q <= collide;
    end
  end

  // Scoreboard: reset, then flush, then reservation set, then write clear.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      busy_q <= '0;
    end else begin
      for (int r = 0; r < int'(NUM_WORDS); r++) begin
        if (reserve_ready_o && (reserve_addr_i == AW'(r))) busy_q[r] <= 1'b1;
        else if (wr_en[r])                                 busy_q[r] <= 1'b0;
      end
    end
  end

  assign busy_o     = busy_q;
  assign wcollide_o = wcollide_q;

endmodule

// File: tb/tb_fpu_ss_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_fpu_ss_regfile_sb
//   Directed bench for fpu_ss_regfile_sb. Two instances share all inputs:
//   dut_f (FORWARD=1, 32 words) and dut_r (FORWARD=0, 24 words) so forwarding
//   and out-of-range behaviour are observed side by side.
// -----------------------------------------------------------------------------
module tb_fpu_ss_regfile_sb;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [2:0][4:0]  raddr;
  logic [1:0][4:0]  waddr;
  logic [1:0][31:0] wdata;
  logic [1:0]       we;
  logic             res_valid;
  logic [4:0]       res_addr;
  logic             flush;

  logic [2:0][31:0] rdata_f, rdata_r;
  logic [2:0]       rbusy_f, rbusy_r;
  logic             ready_f, ready_r;
  logic [31:0]      busy_f;
  logic [23:0]      busy_r;
  logic             coll_f, coll_r;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  fpu_ss_regfile_sb #(.FLEN(32), .NUM_WORDS(32), .NUM_RPORTS(3),
                      .NUM_WPORTS(2), .FORWARD(1)) dut_f (
    .clk_i(clk_i), .rst_i(rst_i),
    .raddr_i(raddr), .rdata_o(rdata_f), .rbusy_o(rbusy_f),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .reserve_valid_i(res_valid), .reserve_addr_i(res_addr),
    .reserve_ready_o(ready_f), .flush_i(flush),
    .busy_o(busy_f), .wcollide_o(coll_f)
  );

  fpu_ss_regfile_sb #(.FLEN(32), .NUM_WORDS(24), .NUM_RPORTS(3),
                      .NUM_WPORTS(2), .FORWARD(0)) dut_r (
    .clk_i(clk_i), .rst_i(rst_i),
    .raddr_i(raddr), .rdata_o(rdata_r), .rbusy_o(rbusy_r),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .reserve_valid_i(res_valid), .reserve_addr_i(res_addr),
    .reserve_ready_o(ready_r), .flush_i(flush),
    .busy_o(busy_r), .wcollide_o(coll_r)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    we        = 2'b00;
    res_valid = 1'b0;
    flush     = 1'b0;
    rst_i     = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush = 1'b0; res_valid = 1'b0; res_addr = 5'd0;
    we = 2'b11; waddr[0] = 5'd5; waddr[1] = 5'd5;
    wdata[0] = 32'h1111_1111; wdata[1] = 32'h2222_2222;
    raddr[0] = 5'd5; raddr[1] = 5'd6; raddr[2] = 5'd0;
    tick(); tick();
    idle();
    #1;
    n_checks++; if (rdata_f[0] !== 32'h0) $display("FAIL rst_rdata_f0: got %h exp 0", rdata_f[0]); else n_pass++;
    n_checks++; if (rdata_r[0] !== 32'h0) $display("FAIL rst_rdata_r0: got %h exp 0", rdata_r[0]); else n_pass++;
    n_checks++; if (rdata_f[2] !== 32'h0) $display("FAIL rst_rdata_f2: got %h exp 0", rdata_f[2]); else n_pass++;
    n_checks++; if (busy_f !== 32'h0) $display("FAIL rst_busy_f: got %h exp 0", busy_f); else n_pass++;
    n_checks++; if (rbusy_f !== 3'b000) $display("FAIL rst_rbusy_f: got %b exp 000", rbusy_f); else n_pass++;
    n_checks++; if (coll_f !== 1'b0) $display("FAIL rst_wcollide_f: got %b exp 0", coll_f); else n_pass++;
    res_valid = 1'b1;
    #1;
    n_checks++; if (ready_f !== 1'b1) $display("FAIL rst_ready_f: got %b exp 1", ready_f); else n_pass++;
    res_valid = 1'b0;
    #1;
    n_checks++; if (ready_f !== 1'b0) $display("FAIL rst_ready_idle_f: got %b exp 0", ready_f); else n_pass++;
  endtask

  task automatic test_write_read();
    raddr[0] = 5'd5;
    we = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'h3F80_0000;
    #1;
    n_checks++; if (rdata_f[0] !== 32'h3F80_0000) $display("FAIL fwd_same_cycle: got %h exp 3f800000", rdata_f[0]); else n_pass++;
    n_checks++; if (rdata_r[0] !== 32'h0) $display("FAIL nofwd_same_cycle: got %h exp 0", rdata_r[0]); else n_pass++;
    tick();
    idle();
    #1;
    n_checks++; if (rdata_f[0] !== 32'h3F80_0000) $display("FAIL fwd_next_cycle: got %h exp 3f800000", rdata_f[0]); else n_pass++;
    n_checks++; if (rdata_r[0] !== 32'h3F80_0000) $display("FAIL nofwd_next_cycle: got %h exp 3f800000", rdata_r[0]); else n_pass++;
    n_checks++; if (busy_f[5] !== 1'b0) $display("FAIL write_nonbusy: got %b exp 0", busy_f[5]); else n_pass++;
    tick();
    n_checks++; if (rdata_r[0] !== 32'h3F80_0000) $display("FAIL nofwd_later: got %h exp 3f800000", rdata_r[0]); else n_pass++;
  endtask

  task automatic test_priority();
    raddr[1] = 5'd7;
    we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7;
    wdata[0] = 32'hAAAA_AAAA; wdata[1] = 32'h5555_5555;
    #1;
    n_checks++; if (rdata_f[1] !== 32'h5555_5555) $display("FAIL prio_fwd: got %h exp 55555555", rdata_f[1]); else n_pass++;
    n_checks++; if (coll_f !== 1'b0) $display("FAIL prio_coll_early: got %b exp 0", coll_f); else n_pass++;
    tick();
    idle();
    #1;
    n_checks++; if (rdata_f[1] !== 32'h5555_5555) $display("FAIL prio_mem_f: got %h exp 55555555", rdata_f[1]); else n_pass++;
    n_checks++; if (rdata_r[1] !== 32'h5555_5555) $display("FAIL prio_mem_r: got %h exp 55555555", rdata_r[1]); else n_pass++;
    n_checks++; if (coll_f !== 1'b1) $display("FAIL prio_coll_f: got %b exp 1", coll_f); else n_pass++;
    n_checks++; if (coll_r !== 1'b1) $display("FAIL prio_coll_r: got %b exp 1", coll_r); else n_pass++;
    tick();
    n_checks++; if (coll_f !== 1'b0) $display("FAIL prio_coll_pulse: got %b exp 0", coll_f); else n_pass++;
  endtask

  task automatic test_scoreboard();
    raddr[2] = 5'd3;
    res_valid = 1'b1; res_addr = 5'd3;
    #1;
    n_checks++; if (ready_f !== 1'b1) $display("FAIL sb_reserve_ready: got %b exp 1", ready_f); else n_pass++;
    tick();
    idle();
    #1;
    n_checks++; if (busy_f[3] !== 1'b1) $display("FAIL sb_busy_set: got %b exp 1", busy_f[3]); else n_pass++;
    n_checks++; if (rbusy_f[2] !== 1'b1) $display("FAIL sb_rbusy: got %b exp 1", rbusy_f[2]); else n_pass++;
    res_valid = 1'b1;
    #1;
    n_checks++; if (ready_f !== 1'b0) $display("FAIL sb_rereserve: got %b exp 0", ready_f); else n_pass++;
    tick();
    idle();
    we = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'h0000_0001;
    #1;
    n_checks++; if (rbusy_f[2] !== 1'b1) $display("FAIL sb_rbusy_no_fwd: got %b exp 1", rbusy_f[2]); else n_pass++;
    tick();
    idle();
    #1;
    n_checks++; if (busy_f[3] !== 1'b0) $display("FAIL sb_write_clear: got %b exp 0", busy_f[3]); else n_pass++;
    // reserve and write r3 together while free: set wins
    res_valid = 1'b1; we = 2'b01;
    #1;
    n_checks++; if (ready_f !== 1'b1) $display("FAIL sb_rw_ready: got %b exp 1", ready_f); else n_pass++;
    tick();
    idle();
    #1;
    n_checks++; if (busy_f[3] !== 1'b1) $display("FAIL sb_set_wins_f: got %b exp 1", busy_f[3]); else n_pass++;
    n_checks++; if (busy_r[3] !== 1'b1) $display("FAIL sb_set_wins_r: got %b exp 1", busy_r[3]); else n_pass++;
    // reserve while busy and being cleared: still rejected, ends clear
    res_valid = 1'b1; we = 2'b01;
    #1;
    n_checks++; if (ready_f !== 1'b0) $display("FAIL sb_no_bypass: got %b exp 0", ready_f); else n_pass++;
    tick();
    idle();
    #1;
    n_checks++; if (busy_f[3] !== 1'b0) $display("FAIL sb_clear_after_reject: got %b exp 0", busy_f[3]); else n_pass++;
  endtask

  task automatic test_flush();
    logic [4:0] regs [3];
    regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd9;
    foreach (regs[k]) begin
      res_valid = 1'b1; res_addr = regs[k];
      tick();
    end
    idle();
    raddr[0] = 5'd5; raddr[1] = 5'd7;
    #1;
    n_checks++; if (busy_f !== 32'h0000_0206) $display("FAIL fl_busy_pre_f: got %h exp 00000206", busy_f); else n_pass++;
    n_checks++; if (busy_r !== 24'h00_0206) $display("FAIL fl_busy_pre_r: got %h exp 000206", busy_r); else n_pass++;
    flush = 1'b1; res_valid = 1'b1; res_addr = 5'd4;
    #1;
    n_checks++; if (ready_f !== 1'b0) $display("FAIL fl_ready: got %b exp 0", ready_f); else n_pass++;
    tick();
    idle();
    #1;
    n_checks++; if (busy_f !== 32'h0) $display("FAIL fl_busy_f: got %h exp 0", busy_f); else n_pass++;
    n_checks++; if (busy_r !== 24'h0) $display("FAIL fl_busy_r: got %h exp 0", busy_r); else n_pass++;
    n_checks++; if (rdata_f[0] !== 32'h3F80_0000) $display("FAIL fl_mem5: got %h exp 3f800000", rdata_f[0]); else n_pass++;
    n_checks++; if (rdata_f[1] !== 32'h5555_5555) $display("FAIL fl_mem7: got %h exp 55555555", rdata_f[1]); else n_pass++;
  endtask

  task automatic test_out_of_range();
    raddr[0] = 5'd30;
    we = 2'b01; waddr[0] = 5'd30; wdata[0] = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (rdata_r[0] !== 32'h0) $display("FAIL oor_read_same: got %h exp 0", rdata_r[0]); else n_pass++;
    n_checks++; if (rdata_f[0] !== 32'hDEAD_BEEF) $display("FAIL inr_fwd30: got %h exp deadbeef", rdata_f[0]); else n_pass++;
    tick();
    idle();
    #1;
    n_checks++; if (rdata_r[0] !== 32'h0) $display("FAIL oor_read_next: got %h exp 0", rdata_r[0]); else n_pass++;
    n_checks++; if (rbusy_r[0] !== 1'b0) $display("FAIL oor_rbusy: got %b exp 0", rbusy_r[0]); else n_pass++;
    n_checks++; if (rdata_f[0] !== 32'hDEAD_BEEF) $display("FAIL inr_mem30: got %h exp deadbeef", rdata_f[0]); else n_pass++;
  endtask

  task automatic test_mid_reset();
    raddr[0] = 5'd6; raddr[1] = 5'd7;
    res_valid = 1'b1; res_addr = 5'd6;
    we = 2'b01; waddr[0] = 5'd6; wdata[0] = 32'h1234_5678;
    rst_i = 1'b1;
    tick();
    idle();
    #1;
    n_checks++; if (busy_f[6] !== 1'b0) $display("FAIL mr_busy6: got %b exp 0", busy_f[6]); else n_pass++;
    n_checks++; if (rdata_f[0] !== 32'h0) $display("FAIL mr_mem6_f: got %h exp 0", rdata_f[0]); else n_pass++;
    n_checks++; if (rdata_r[0] !== 32'h0) $display("FAIL mr_mem6_r: got %h exp 0", rdata_r[0]); else n_pass++;
    n_checks++; if (rdata_f[1] !== 32'h0) $display("FAIL mr_mem7: got %h exp 0", rdata_f[1]); else n_pass++;
  endtask

  initial begin
    raddr = '0; waddr = '0; wdata = '0; we = '0;
    res_valid = 1'b0; res_addr = '0; flush = 1'b0; rst_i = 1'b1;
    test_reset();
    test_write_read();
    test_priority();
    test_scoreboard();
    test_flush();
    test_out_of_range();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
